// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - round-robin scheduler sharing one multi-cycle binary-to-BCD converter
// Optional feature macro: BCD_SCHED_TIMEOUT_EN (abort a conversion after TIMEOUT_CYC cycles in WAIT)
module bcd_conv_scheduler #(
  parameter int N_REQ       = 2,
  parameter int WIDTH       = 12,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] bin_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic [11:0]            bcd_o,
  output logic                   ovf_o,
  output logic                   err_o,
  output logic                   conv_start_o,
  output logic [WIDTH-1:0]       conv_bin_o,
  input  logic                   conv_done_i,
  input  logic [11:0]            conv_bcd_i
);

  localparam int               PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] MAX_OP = WIDTH'(999);

  typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_q;
  logic [PTR_W-1:0] win_pick;
  logic             found;
  logic [WIDTH-1:0] op_pick;
  logic             ovf_q;
  logic             take;
  logic             deliver_go;
  logic             timeout;

  // Requester index reached by stepping offs places past base, wrapping at N_REQ.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // Round-robin search: first active request at or after the pointer.
  always_comb begin
    found    = 1'b0;
    win_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[rr_index(ptr, i)]) begin
        found    = 1'b1;
        win_pick = rr_index(ptr, i);
      end
    end
  end

  assign op_pick    = bin_i[win_pick*WIDTH +: WIDTH];
  assign take       = (state == IDLE) && found;
  assign deliver_go = (state == WAIT) && (state_next == DELIVER);

  // Next-state logic; conv_done_i only matters while waiting on the converter.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (found) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (conv_done_i || timeout) state_next = DELIVER;
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Latch winner and clamped operand on the grant decision; held for the whole slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q      <= '0;
      conv_bin_o <= '0;
      ovf_q      <= 1'b0;
    end else if (take) begin
      win_q <= win_pick;
      if (op_pick > MAX_OP) begin
        conv_bin_o <= MAX_OP;
        ovf_q      <= 1'b1;
      end else begin
        conv_bin_o <= op_pick;
        ovf_q      <= 1'b0;
      end
    end
  end

  // Single-cycle handshake pulses, registered from the state transitions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_o        <= '0;
      ack_o        <= '0;
      conv_start_o <= 1'b0;
    end else begin
      gnt_o        <= '0;
      ack_o        <= '0;
      conv_start_o <= take;
      if (take)       gnt_o[win_pick] <= 1'b1;
      if (deliver_go) ack_o[win_q]    <= 1'b1;
    end
  end

  // Publish the result and advance the round-robin pointer past the served requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_o <= '0;
      ovf_o <= 1'b0;
      ptr   <= '0;
    end else if (deliver_go) begin
      ptr <= (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      if (timeout) begin
        bcd_o <= 12'hFFF;
        ovf_o <= 1'b0;
      end else begin
        bcd_o <= conv_bcd_i;
        ovf_o <= ovf_q;
      end
    end
  end

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // A real completion on the last allowed cycle wins over the abort.
  assign timeout = (state == WAIT) && !conv_done_i && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  // Count cycles spent in WAIT; cleared outside it so every slot starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  // Error flag follows each delivery: set on abort, cleared by a real result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           err_q <= 1'b0;
    else if (deliver_go) err_q <= timeout;
  end
`else
  // Parameter kept so both builds share one parameter list.
  localparam int timeout_cyc_unused = TIMEOUT_CYC;

  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - randomized self-checking bench for bcd_conv_scheduler
`timescale 1ns/1ps
module tb_bcd_conv_scheduler;

  localparam int N    = 3;
  localparam int W    = 12;
  localparam int TCYC = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] bin;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [11:0]    bcd;
  logic           ovf;
  logic           err;
  logic           start;
  logic [W-1:0]   conv_bin;
  logic           done;
  logic [11:0]    conv_bcd;

  int          checks = 0;
  int          errors = 0;
  int          ptr_m  = 0;
  int          bin_val [N];
  logic [11:0] last_bcd = '0;
  bit          in_deliver;
  int          n;

  bcd_conv_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TCYC)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .bin_i(bin),
    .gnt_o(gnt), .ack_o(ack), .bcd_o(bcd), .ovf_o(ovf), .err_o(err),
    .conv_start_o(start), .conv_bin_o(conv_bin),
    .conv_done_i(done), .conv_bcd_i(conv_bcd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bins;
    for (int i = 0; i < N; i++) bin[i*W +: W] = W'(bin_val[i]);
  endtask

  // One complete service slot; converter answers lat cycles into WAIT.
  task automatic do_slot(input int exp_wait, input int lat, input bit drop, input bit spur, input bit mutate);
    int           w;
    int           k;
    int           raw;
    logic [W-1:0] cv;
    w   = rr_pick(req, ptr_m);
    raw = bin_val[w];
    k   = 0;
    do begin tick; k++; end while (gnt == '0 && k < 20);
    check_eq("gnt_wait", 32'(k), 32'(exp_wait));
    check_eq("gnt", 32'(gnt), 32'(1 << w));
    check_eq("start", 32'(start), 32'd1);
    check_eq("conv_bin", 32'(conv_bin), 32'(clamp(raw)));
    check_eq("bcd_hold", 32'(bcd), 32'(last_bcd));
    cv = conv_bin;
    if (drop) req[w] = 1'b0;
    if (mutate) begin
      bin_val[w] = $urandom_range(0, 4095);
      drive_bins();
    end
    if (spur) begin
      done     = 1'b1;
      conv_bcd = 12'hABC;
    end
    tick;
    done = 1'b0;
    check_eq("gnt_pulse", 32'(gnt), 32'd0);
    check_eq("start_pulse", 32'(start), 32'd0);
    check_eq("no_early_ack", 32'(ack), 32'd0);
    for (int j = 1; j < lat; j++) begin
      tick;
      check_eq("no_early_ack", 32'(ack), 32'd0);
    end
    done     = 1'b1;
    conv_bcd = to_bcd(int'(cv));
    tick;
    done = 1'b0;
    check_eq("ack", 32'(ack), 32'(1 << w));
    check_eq("bcd", 32'(bcd), 32'(to_bcd(clamp(raw))));
    check_eq("ovf", 32'(ovf), 32'(raw > 999));
    check_eq("err", 32'(err), 32'd0);
    last_bcd = to_bcd(clamp(raw));
    ptr_m    = (w + 1) % N;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    done     = 1'b0;
    conv_bcd = '0;
    for (int i = 0; i < N; i++) bin_val[i] = 0;
    drive_bins();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_conv_bin", 32'(conv_bin), 32'd0);
    rst = 1'b0;
    tick;

    // Single requester, slow converter.
    bin_val[0] = 255;
    drive_bins();
    req = 3'b001;
    do_slot(1, 20, 0, 0, 0);
    req = '0;
    repeat (5) begin
      tick;
      check_eq("idle_no_gnt", 32'(gnt), 32'd0);
    end

    // Two requesters held: strict alternation, back-to-back slots.
    bin_val[0] = 7;
    bin_val[1] = 42;
    drive_bins();
    req = 3'b011;
    do_slot(1, $urandom_range(1, 6), 0, 0, 0);
    repeat (3) do_slot(2, $urandom_range(1, 6), 0, 0, 0);
    req = '0;
    tick;

    // Oversized operand clamps; request dropped after grant still gets its ack.
    bin_val[1] = 4095;
    drive_bins();
    req = 3'b010;
    do_slot(1, 5, 1, 1, 0);
    repeat (8) begin
      tick;
      check_eq("drop_no_regrant", 32'(gnt), 32'd0);
    end

    // Reset while waiting on the converter.
    bin_val[2] = 500;
    drive_bins();
    req = 3'b100;
    tick;
    check_eq("pre_rst_gnt", 32'(gnt), 32'(1 << rr_pick(3'b100, ptr_m)));
    req = '0;
    repeat (3) tick;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    check_eq("mid_rst_bcd", 32'(bcd), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
    check_eq("mid_rst_start", 32'(start), 32'd0);
    check_eq("mid_rst_conv_bin", 32'(conv_bin), 32'd0);
    #1;
    rst      = 1'b0;
    ptr_m    = 0;
    last_bcd = '0;
    done     = 1'b1;
    conv_bcd = 12'h123;
    tick;
    done = 1'b0;
    check_eq("post_rst_no_ack", 32'(ack), 32'd0);
    check_eq("post_rst_bcd", 32'(bcd), 32'd0);
    req = 3'b110;
    do_slot(1, 3, 0, 0, 0);
    req = '0;
    tick;

    // Randomized traffic against the round-robin model.
    in_deliver = 1'b0;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++)
        bin_val[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 4095) : $urandom_range(0, 999);
      drive_bins();
      req = N'($urandom_range(1, (1 << N) - 1));
      do_slot(in_deliver ? 2 : 1, $urandom_range(1, 8), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1);
      in_deliver = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) begin
          tick;
          check_eq("gap_no_gnt", 32'(gnt), 32'd0);
        end
        in_deliver = 1'b0;
      end
    end

`ifdef BCD_SCHED_TIMEOUT_EN
    // Converter never answers: abort after TCYC cycles, late done ignored.
    req = '0;
    if (in_deliver) tick;
    bin_val[0] = 2000;
    drive_bins();
    req = 3'b001;
    ptr_m = 0;
    tick;
    check_eq("to_gnt", 32'(gnt), 32'(1 << rr_pick(3'b001, 0)));
    req = '0;
    n = 0;
    do begin tick; n++; end while (ack == '0 && n < 100);
    check_eq("to_cycles", 32'(n), 32'(TCYC + 1));
    check_eq("to_ack", 32'(ack), 32'd1);
    check_eq("to_bcd", 32'(bcd), 32'hFFF);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_ovf", 32'(ovf), 32'd0);
    tick;
    done     = 1'b1;
    conv_bcd = 12'h100;
    tick;
    done = 1'b0;
    check_eq("late_done_no_ack", 32'(ack), 32'd0);
    check_eq("late_done_bcd", 32'(bcd), 32'hFFF);
    check_eq("late_done_err", 32'(err), 32'd1);
    last_bcd   = 12'hFFF;
    ptr_m      = 1;
    bin_val[1] = 321;
    drive_bins();
    req = 3'b011;
    do_slot(1, 4, 1, 0, 0);
    req = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
